// File: rtl/axi_top_pkg.sv
// Shared types and widths for the AXI4 command-to-transaction master bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axi_top_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 32;
  localparam int ID_W      = 1;
  localparam int LEN_W     = 8;
  localparam int STRB_W    = 4;
  localparam int TOP_LEN_W = 6;
  localparam int SIZE_W    = 3;
  localparam int BURST_W   = 2;
  localparam int RESP_W    = 2;
  localparam int PROT_W    = 3;

  typedef enum logic [BURST_W-1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_AW   = 2'd1,
    WR_W    = 2'd2,
    WR_B    = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2
  } rd_state_t;

  // Command fields captured on a start edge; held for the whole transaction.
  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [TOP_LEN_W-1:0] len;
    logic [BURST_W-1:0]   burst;
    logic [SIZE_W-1:0]    size;
  } cmd_t;

endpackage

// File: rtl/axi_top_if.sv
// AXI4 five-channel bundle (AW, W, B, AR, R) between the bridge and a slave.
// Latency: n/a (wiring only).
// Backpressure: standard AXI valid/ready on every channel.
// Modports: master drives AW/W/AR payload+valid and B/R ready; slave the reverse.
interface axi_top_if;
  import axi_top_pkg::*;

  logic [ADDR_W-1:0]  io_AW_ADDR;
  logic [LEN_W-1:0]   io_AW_LEN;
  logic [SIZE_W-1:0]  io_AW_SIZE;
  logic [BURST_W-1:0] io_AW_BURST;
  logic [ID_W-1:0]    io_AW_ID;
  logic [PROT_W-1:0]  io_AW_PROT;
  logic               io_AW_VALID;
  logic               io_AW_READY;

  logic [DATA_W-1:0]  io_W_DATA;
  logic [STRB_W-1:0]  io_W_STRB;
  logic               io_W_LAST;
  logic               io_W_VALID;
  logic               io_W_READY;

  logic [ID_W-1:0]    io_B_ID;
  logic [RESP_W-1:0]  io_B_RESP;
  logic               io_B_VALID;
  logic               io_B_READY;

  logic [ADDR_W-1:0]  io_AR_ADDR;
  logic [LEN_W-1:0]   io_AR_LEN;
  logic [SIZE_W-1:0]  io_AR_SIZE;
  logic [BURST_W-1:0] io_AR_BURST;
  logic [ID_W-1:0]    io_AR_ID;
  logic [PROT_W-1:0]  io_AR_PROT;
  logic               io_AR_VALID;
  logic               io_AR_READY;

  logic [DATA_W-1:0]  io_R_DATA;
  logic               io_R_LAST;
  logic [ID_W-1:0]    io_R_ID;
  logic [RESP_W-1:0]  io_R_RESP;
  logic               io_R_VALID;
  logic               io_R_READY;

  modport master (
    output io_AW_ADDR, io_AW_LEN, io_AW_SIZE, io_AW_BURST, io_AW_ID, io_AW_PROT, io_AW_VALID,
    input  io_AW_READY,
    output io_W_DATA, io_W_STRB, io_W_LAST, io_W_VALID,
    input  io_W_READY,
    input  io_B_ID, io_B_RESP, io_B_VALID,
    output io_B_READY,
    output io_AR_ADDR, io_AR_LEN, io_AR_SIZE, io_AR_BURST, io_AR_ID, io_AR_PROT, io_AR_VALID,
    input  io_AR_READY,
    input  io_R_DATA, io_R_LAST, io_R_ID, io_R_RESP, io_R_VALID,
    output io_R_READY
  );

  modport slave (
    input  io_AW_ADDR, io_AW_LEN, io_AW_SIZE, io_AW_BURST, io_AW_ID, io_AW_PROT, io_AW_VALID,
    output io_AW_READY,
    input  io_W_DATA, io_W_STRB, io_W_LAST, io_W_VALID,
    output io_W_READY,
    output io_B_ID, io_B_RESP, io_B_VALID,
    input  io_B_READY,
    input  io_AR_ADDR, io_AR_LEN, io_AR_SIZE, io_AR_BURST, io_AR_ID, io_AR_PROT, io_AR_VALID,
    output io_AR_READY,
    output io_R_DATA, io_R_LAST, io_R_ID, io_R_RESP, io_R_VALID,
    input  io_R_READY
  );

endinterface

// File: rtl/axi_top.sv
// AXI4 master bridge: turns WR/RD strobe edges on the command port into AXI4 bursts.
// Latency: AW/AR valid the cycle after the start edge; W follows AW acceptance; RDATA the cycle after each R beat.
// Backpressure: every valid held with stable payload until ready; start edges while busy are dropped.
// Ports: clock/reset (sync, active-high); io_TOP_* command port; axi = AXI4 master side.
module axi_top
  import axi_top_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_TOP_WR,
  input  logic                 io_TOP_RD,
  input  logic [ADDR_W-1:0]    io_TOP_ADDRESS,
  input  logic [DATA_W-1:0]    io_TOP_WDATA,
  output logic [DATA_W-1:0]    io_TOP_RDATA,
  input  logic [TOP_LEN_W-1:0] io_TOP_LENGTH,
  input  logic [BURST_W-1:0]   io_TOP_BURST,
  input  logic [SIZE_W-1:0]    io_TOP_SIZE,
  axi_top_if.master            axi
);

  wr_state_t            wr_state, wr_state_nxt;
  rd_state_t            rd_state, rd_state_nxt;

  logic                 wr_q, rd_q;
  logic                 wr_start, rd_start;
  cmd_t                 wr_cmd_q, rd_cmd_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [TOP_LEN_W-1:0] beat_cnt;
  logic [RESP_W-1:0]    bresp_q;
  logic [DATA_W-1:0]    rdata_q;

  logic aw_vld, w_vld, w_last, b_rdy;
  logic ar_vld, r_rdy;
  logic wr_latch, rd_latch, cnt_clr, cnt_inc;

  // Rising-edge detect: a level held high never retriggers.
  assign wr_start = io_TOP_WR & ~wr_q;
  assign rd_start = io_TOP_RD & ~rd_q;

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  // Write FSM: AW first, then LEN+1 W beats, then wait for B.
  always_comb begin
    wr_state_nxt = wr_state;
    aw_vld       = 1'b0;
    w_vld        = 1'b0;
    w_last       = 1'b0;
    b_rdy        = 1'b0;
    wr_latch     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (wr_start) begin
          wr_latch     = 1'b1;
          wr_state_nxt = WR_AW;
        end
      end
      WR_AW: begin
        aw_vld = 1'b1;
        if (axi.io_AW_READY) begin
          cnt_clr      = 1'b1;
          wr_state_nxt = WR_W;
        end
      end
      WR_W: begin
        w_vld  = 1'b1;
        w_last = (beat_cnt == wr_cmd_q.len);
        if (axi.io_W_READY) begin
          if (w_last) wr_state_nxt = WR_B;
          else        cnt_inc      = 1'b1;
        end
      end
      WR_B: begin
        b_rdy = 1'b1;
        if (axi.io_B_VALID) wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // Read FSM: AR, then accept beats until the one flagged LAST.
  always_comb begin
    rd_state_nxt = rd_state;
    ar_vld       = 1'b0;
    r_rdy        = 1'b0;
    rd_latch     = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (rd_start) begin
          rd_latch     = 1'b1;
          rd_state_nxt = RD_AR;
        end
      end
      RD_AR: begin
        ar_vld = 1'b1;
        if (axi.io_AR_READY) rd_state_nxt = RD_R;
      end
      RD_R: begin
        r_rdy = 1'b1;
        if (axi.io_R_VALID && axi.io_R_LAST) rd_state_nxt = RD_IDLE;
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Edge-detect, command latches, beat counter and read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_cmd_q <= '0;
      rd_cmd_q <= '0;
      wdata_q  <= '0;
      beat_cnt <= '0;
      bresp_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_q <= io_TOP_WR;
      rd_q <= io_TOP_RD;
      if (wr_latch) begin
        wr_cmd_q <= '{addr: io_TOP_ADDRESS, len: io_TOP_LENGTH, burst: io_TOP_BURST, size: io_TOP_SIZE};
        wdata_q  <= io_TOP_WDATA;
      end
      if (rd_latch) begin
        rd_cmd_q <= '{addr: io_TOP_ADDRESS, len: io_TOP_LENGTH, burst: io_TOP_BURST, size: io_TOP_SIZE};
      end
      if (cnt_clr)      beat_cnt <= '0;
      else if (cnt_inc) beat_cnt <= beat_cnt + TOP_LEN_W'(1);
      if (b_rdy && axi.io_B_VALID) bresp_q <= axi.io_B_RESP;
      if (r_rdy && axi.io_R_VALID) rdata_q <= axi.io_R_DATA;
    end
  end

  // The write response and read ID/RESP are accepted but not acted upon.
  logic unused_resp;
  assign unused_resp = ^{bresp_q, axi.io_B_ID, axi.io_R_ID, axi.io_R_RESP};

  // Address is never incremented here; the slave walks the burst itself.
  assign axi.io_AW_ADDR  = wr_cmd_q.addr;
  assign axi.io_AW_LEN   = {{(LEN_W-TOP_LEN_W){1'b0}}, wr_cmd_q.len};
  assign axi.io_AW_SIZE  = wr_cmd_q.size;
  assign axi.io_AW_BURST = wr_cmd_q.burst;
  assign axi.io_AW_ID    = '0;
  assign axi.io_AW_PROT  = '0;
  assign axi.io_AW_VALID = aw_vld;

  assign axi.io_W_DATA   = wdata_q;
  assign axi.io_W_STRB   = {STRB_W{1'b1}};
  assign axi.io_W_LAST   = w_last;
  assign axi.io_W_VALID  = w_vld;

  assign axi.io_B_READY  = b_rdy;

  assign axi.io_AR_ADDR  = rd_cmd_q.addr;
  assign axi.io_AR_LEN   = {{(LEN_W-TOP_LEN_W){1'b0}}, rd_cmd_q.len};
  assign axi.io_AR_SIZE  = rd_cmd_q.size;
  assign axi.io_AR_BURST = rd_cmd_q.burst;
  assign axi.io_AR_ID    = '0;
  assign axi.io_AR_PROT  = '0;
  assign axi.io_AR_VALID = ar_vld;

  assign axi.io_R_READY  = r_rdy;

  assign io_TOP_RDATA    = rdata_q;

endmodule

// File: tb/tb_axi_top.sv
// Directed bench for axi_top with a behavioural zero-wait (optionally stalling) AXI4 word memory.
// Slave reacts on the falling edge, so every handshake it grants completes on the next rising edge.
// Protocol counters kept by the slave are compared against hand-computed expectations.
module tb_axi_top;
  import axi_top_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_TOP_WR, io_TOP_RD;
  logic [5:0]  io_TOP_ADDRESS;
  logic [31:0] io_TOP_WDATA;
  logic [31:0] io_TOP_RDATA;
  logic [5:0]  io_TOP_LENGTH;
  logic [1:0]  io_TOP_BURST;
  logic [2:0]  io_TOP_SIZE;

  axi_top_if bus();

  axi_top dut (
    .clock          (clock),
    .reset          (reset),
    .io_TOP_WR      (io_TOP_WR),
    .io_TOP_RD      (io_TOP_RD),
    .io_TOP_ADDRESS (io_TOP_ADDRESS),
    .io_TOP_WDATA   (io_TOP_WDATA),
    .io_TOP_RDATA   (io_TOP_RDATA),
    .io_TOP_LENGTH  (io_TOP_LENGTH),
    .io_TOP_BURST   (io_TOP_BURST),
    .io_TOP_SIZE    (io_TOP_SIZE),
    .axi            (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave memory and statistics (written only by the slave process)
  logic [31:0] mem [16];
  int aw_cnt = 0, w_cnt = 0, wlast_cnt = 0, wlast_bad = 0, b_cnt = 0;
  int ar_cnt = 0, r_beats = 0, r_done = 0;
  int aw_bad = 0, w_bad = 0, aw_stalled = 0, w_stalled = 0;
  logic [7:0] aw_len_seen = '0, ar_len_seen = '0;
  logic [3:0] strb_seen = '0;
  int aw_stall_cfg = 0, w_stall_cfg = 0;  // written only by the stimulus process

  initial begin
    logic        b_pending, r_active, aw_seen, w_seen, aw_hs_prev;
    logic [3:0]  wr_idx, rd_idx;
    logic [7:0]  wr_len, wr_beat, rd_len, rd_beat;
    logic [1:0]  wr_burst, rd_burst;
    logic [18:0] aw_snap;
    logic [36:0] w_snap;
    int          aw_wait, w_wait;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    b_pending = 0; r_active = 0; aw_seen = 0; w_seen = 0; aw_hs_prev = 0;
    wr_idx = 0; rd_idx = 0; wr_len = 0; wr_beat = 0; rd_len = 0; rd_beat = 0;
    wr_burst = 0; rd_burst = 0; aw_snap = 0; w_snap = 0; aw_wait = 0; w_wait = 0;
    bus.io_AW_READY = 0; bus.io_W_READY = 0; bus.io_AR_READY = 0;
    bus.io_B_VALID = 0; bus.io_B_ID = 0; bus.io_B_RESP = RESP_OKAY;
    bus.io_R_VALID = 0; bus.io_R_DATA = 0; bus.io_R_LAST = 0; bus.io_R_ID = 0; bus.io_R_RESP = RESP_OKAY;
    forever begin
      @(negedge clock);
      if (reset) begin
        b_pending = 0; r_active = 0; aw_seen = 0; w_seen = 0; aw_hs_prev = 0; wr_beat = 0;
        bus.io_AW_READY = 0; bus.io_W_READY = 0; bus.io_AR_READY = 0;
        bus.io_B_VALID = 0; bus.io_R_VALID = 0; bus.io_R_LAST = 0;
      end else begin
        // B channel
        bus.io_B_VALID = b_pending;
        if (b_pending && bus.io_B_READY) begin b_cnt++; b_pending = 0; end
        // R channel
        if (r_active) begin
          bus.io_R_VALID = 1; bus.io_R_DATA = mem[rd_idx]; bus.io_R_LAST = (rd_beat == rd_len);
          if (bus.io_R_READY) begin
            r_beats++;
            if (bus.io_R_LAST) begin r_active = 0; r_done++; end
            else begin rd_beat++; if (rd_burst != 2'd0) rd_idx++; end
          end
        end else begin
          bus.io_R_VALID = 0; bus.io_R_LAST = 0;
        end
        // AW channel: payload must hold while stalled, valid must drop after acceptance
        if (bus.io_AW_VALID) begin
          if (aw_hs_prev) aw_bad++;
          if (!aw_seen) begin
            aw_seen = 1; aw_wait = aw_stall_cfg;
            aw_snap = {bus.io_AW_ADDR, bus.io_AW_LEN, bus.io_AW_SIZE, bus.io_AW_BURST};
          end else if (aw_snap != {bus.io_AW_ADDR, bus.io_AW_LEN, bus.io_AW_SIZE, bus.io_AW_BURST}) aw_bad++;
          if (aw_wait > 0) begin
            bus.io_AW_READY = 0; aw_wait--; aw_stalled++; aw_hs_prev = 0;
          end else begin
            bus.io_AW_READY = 1; aw_cnt++; aw_seen = 0; aw_hs_prev = 1;
            wr_idx = bus.io_AW_ADDR[5:2]; wr_len = bus.io_AW_LEN; wr_burst = bus.io_AW_BURST;
            wr_beat = 0; aw_len_seen = bus.io_AW_LEN;
          end
        end else begin
          if (aw_seen) aw_bad++;
          bus.io_AW_READY = 0; aw_hs_prev = 0;
        end
        // W channel
        if (bus.io_W_VALID) begin
          if (!w_seen) begin
            w_seen = 1; w_wait = (wr_beat == 0) ? w_stall_cfg : 0;
            w_snap = {bus.io_W_DATA, bus.io_W_STRB, bus.io_W_LAST};
          end else if (w_snap != {bus.io_W_DATA, bus.io_W_STRB, bus.io_W_LAST}) w_bad++;
          if (w_wait > 0) begin
            bus.io_W_READY = 0; w_wait--; w_stalled++;
          end else begin
            bus.io_W_READY = 1; w_seen = 0; w_cnt++; strb_seen = bus.io_W_STRB;
            if (bus.io_W_LAST != (wr_beat == wr_len)) wlast_bad++;
            mem[wr_idx] = bus.io_W_DATA;
            if (bus.io_W_LAST) begin wlast_cnt++; b_pending = 1; wr_beat = 0; end
            else begin wr_beat++; if (wr_burst != 2'd0) wr_idx++; end
          end
        end else begin
          if (w_seen) w_bad++;
          bus.io_W_READY = 0;
        end
        // AR channel
        if (bus.io_AR_VALID && !r_active) begin
          bus.io_AR_READY = 1; ar_cnt++; ar_len_seen = bus.io_AR_LEN;
          rd_idx = bus.io_AR_ADDR[5:2]; rd_len = bus.io_AR_LEN; rd_burst = bus.io_AR_BURST;
          rd_beat = 0; r_active = 1;
        end else begin
          bus.io_AR_READY = 0;
        end
      end
    end
  end

  task automatic wait_b(input int target, input string tag);
    int n = 0;
    while (b_cnt < target && n < 200) begin @(negedge clock); n++; end
    check(tag, b_cnt, target);
  endtask

  task automatic wait_r(input int target, input string tag);
    int n = 0;
    while (r_done < target && n < 200) begin @(negedge clock); n++; end
    check(tag, r_done, target);
  endtask

  task automatic set_cmd(input logic [5:0] a, input logic [31:0] d, input logic [5:0] l);
    io_TOP_ADDRESS = a; io_TOP_WDATA = d; io_TOP_LENGTH = l;
    io_TOP_BURST = BURST_INCR; io_TOP_SIZE = 3'd2;
  endtask

  initial begin
    logic [31:0] rd_t5;
    int n;
    reset = 1; io_TOP_WR = 0; io_TOP_RD = 0;
    set_cmd(6'h0, 32'h0, 6'd0);
    repeat (3) @(negedge clock);
    check("rst_aw_valid", bus.io_AW_VALID, 0);
    check("rst_w_valid",  bus.io_W_VALID, 0);
    check("rst_b_ready",  bus.io_B_READY, 0);
    check("rst_ar_valid", bus.io_AR_VALID, 0);
    check("rst_r_ready",  bus.io_R_READY, 0);
    check("rst_w_last",   bus.io_W_LAST, 0);
    check("rst_aw_addr",  bus.io_AW_ADDR, 0);
    check("rst_rdata",    io_TOP_RDATA, 0);
    reset = 0;
    repeat (2) @(negedge clock);

    // 1: single-beat write, WR held three cycles
    set_cmd(6'h05, 32'h0756_3314, 6'd0); io_TOP_WR = 1;
    @(negedge clock);
    check("t1_aw_valid", bus.io_AW_VALID, 1);
    check("t1_aw_addr",  bus.io_AW_ADDR, 32'h05);
    check("t1_aw_len",   bus.io_AW_LEN, 0);
    check("t1_aw_size",  bus.io_AW_SIZE, 2);
    check("t1_aw_burst", bus.io_AW_BURST, 1);
    check("t1_aw_idprot", {bus.io_AW_ID, bus.io_AW_PROT}, 0);
    check("t1_w_idle_during_aw", bus.io_W_VALID, 0);
    @(negedge clock);
    check("t1_w_valid", bus.io_W_VALID, 1);
    check("t1_w_last",  bus.io_W_LAST, 1);
    check("t1_w_data",  bus.io_W_DATA, 32'h0756_3314);
    check("t1_aw_dropped", bus.io_AW_VALID, 0);
    @(negedge clock);
    check("t1_b_ready", bus.io_B_READY, 1);
    io_TOP_WR = 0;
    wait_b(1, "t1_b_done");
    repeat (3) @(negedge clock);
    check("t1_aw_cnt", aw_cnt, 1);
    check("t1_w_cnt", w_cnt, 1);
    check("t1_wlast_cnt", wlast_cnt, 1);
    check("t1_strb", strb_seen, 4'hF);
    check("t1_idle", {bus.io_AW_VALID, bus.io_W_VALID, bus.io_B_READY}, 0);

    // 2: single-beat read back
    set_cmd(6'h05, 32'h0, 6'd0); io_TOP_RD = 1;
    @(negedge clock);
    io_TOP_RD = 0;
    check("t2_ar_valid", bus.io_AR_VALID, 1);
    check("t2_ar_addr", bus.io_AR_ADDR, 32'h05);
    wait_r(1, "t2_r_done");
    repeat (2) @(negedge clock);
    check("t2_ar_cnt", ar_cnt, 1);
    check("t2_r_beats", r_beats, 1);
    check("t2_rdata", io_TOP_RDATA, 32'h0756_3314);
    check("t2_r_ready_idle", bus.io_R_READY, 0);

    // 3: four-beat INCR write with a retrigger attempt while busy, then read back
    set_cmd(6'h08, 32'hA5A5_A5A5, 6'd3); io_TOP_WR = 1;
    @(negedge clock); io_TOP_WR = 0;
    @(negedge clock); io_TOP_WR = 1;
    @(negedge clock); io_TOP_WR = 0;
    wait_b(2, "t3_b_done");
    repeat (3) @(negedge clock);
    check("t3_aw_cnt_busy_drop", aw_cnt, 2);
    check("t3_w_cnt", w_cnt, 5);
    check("t3_wlast_cnt", wlast_cnt, 2);
    check("t3_wlast_pos", wlast_bad, 0);
    check("t3_aw_len", aw_len_seen, 3);
    io_TOP_RD = 1;
    @(negedge clock); io_TOP_RD = 0;
    wait_r(2, "t3_r_done");
    repeat (2) @(negedge clock);
    check("t3_r_beats", r_beats, 5);
    check("t3_ar_len", ar_len_seen, 3);
    check("t3_mem_first", mem[2], 32'hA5A5_A5A5);
    check("t3_mem_last", mem[5], 32'hA5A5_A5A5);
    check("t3_rdata", io_TOP_RDATA, 32'hA5A5_A5A5);

    // 4: AW stalled 3 cycles, W stalled 2 cycles
    aw_stall_cfg = 3; w_stall_cfg = 2;
    set_cmd(6'h10, 32'h1234_5678, 6'd1); io_TOP_WR = 1;
    @(negedge clock); io_TOP_WR = 0;
    wait_b(3, "t4_b_done");
    aw_stall_cfg = 0; w_stall_cfg = 0;
    repeat (2) @(negedge clock);
    check("t4_aw_stalled", aw_stalled, 3);
    check("t4_w_stalled", w_stalled, 2);
    check("t4_aw_stable", aw_bad, 0);
    check("t4_w_stable", w_bad, 0);
    check("t4_mem4", mem[4], 32'h1234_5678);
    check("t4_mem5", mem[5], 32'h1234_5678);
    check("t4_rdata_hold", io_TOP_RDATA, 32'hA5A5_A5A5);

    // 5: simultaneous WR and RD edges on the same address
    set_cmd(6'h10, 32'hDEAD_BEEF, 6'd1); io_TOP_WR = 1; io_TOP_RD = 1;
    @(negedge clock); io_TOP_WR = 0; io_TOP_RD = 0;
    wait_b(4, "t5_b_done");
    wait_r(3, "t5_r_done");
    repeat (2) @(negedge clock);
    rd_t5 = io_TOP_RDATA;
    check("t5_rdata_old_or_new", (rd_t5 == 32'h1234_5678 || rd_t5 == 32'hDEAD_BEEF), 1);
    check("t5_mem4", mem[4], 32'hDEAD_BEEF);
    check("t5_mem5", mem[5], 32'hDEAD_BEEF);
    check("t5_r_beats", r_beats, 7);

    // 6: reset while the write sits in the W phase
    w_stall_cfg = 20;
    set_cmd(6'h30, 32'h0000_0055, 6'd0); io_TOP_WR = 1;
    @(negedge clock); io_TOP_WR = 0;
    n = 0;
    while (!bus.io_W_VALID && n < 20) begin @(negedge clock); n++; end
    check("t6_in_w_phase", bus.io_W_VALID, 1);
    reset = 1;
    @(negedge clock);
    check("t6_rst_handshake", {bus.io_AW_VALID, bus.io_W_VALID, bus.io_B_READY,
                               bus.io_AR_VALID, bus.io_R_READY, bus.io_W_LAST}, 0);
    check("t6_rst_aw_addr", bus.io_AW_ADDR, 0);
    check("t6_rst_rdata", io_TOP_RDATA, 0);
    w_stall_cfg = 0; reset = 0;
    repeat (2) @(negedge clock);
    check("t6_abort_no_write", mem[12], 0);
    set_cmd(6'h30, 32'h0000_0066, 6'd0); io_TOP_WR = 1;
    @(negedge clock); io_TOP_WR = 0;
    wait_b(5, "t6_b_done");
    repeat (2) @(negedge clock);
    check("t6_mem12", mem[12], 32'h0000_0066);
    check("t6_wlast_pos", wlast_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
